// File: rtl/mips_uart_tx_arbiter.sv
// mips_uart_tx_arbiter
// Shares one UART transmitter between two word requesters (0 = debug dump,
// 1 = console/echo). Each grant takes one word and sends its 1-4 low bytes
// MSB first over the tx_ready/tx_done handshake. A watchdog aborts a
// stalled byte phase and raises a sticky error flag.
//
// Handshakes:
// - Requester side: valid is held until a one-cycle ack. Dropping valid
//   before the ack withdraws the request.
// - UART side: tx_ready asks for a byte. The UART takes it by dropping
//   tx_done and reports completion by raising tx_done again.
module mips_uart_tx_arbiter #(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req0_valid,
  input  logic [NBITS-1:0]     i_req0_word,
  input  logic [1:0]           i_req0_len,
  output logic                 o_req0_ack,
  input  logic                 i_req1_valid,
  input  logic [NBITS-1:0]     i_req1_word,
  input  logic [1:0]           i_req1_len,
  output logic                 o_req1_ack,
  input  logic                 i_uart_tx_done,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  input  logic                 i_err_clr,
  output logic                 o_busy,
  output logic                 o_grant,
  output logic                 o_error,
  output logic [1:0]           o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int TW = $clog2(TIMEOUT);
  // The abort fires on the edge where the counter would reach TIMEOUT-1,
  // so the counter itself never goes past TIMEOUT-2 and cannot saturate.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             grant_q, grant_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err_q, err_d;
  logic             tx_ready_q;
  logic             busy_q;

  logic             win;
  logic [NBITS-1:0] win_word;
  logic [1:0]       win_len;

  // Pick the winner: round-robin when both requesters are valid,
  // otherwise whichever one is valid.
  always_comb begin
    win      = (i_req0_valid && i_req1_valid) ? ~grant_q : i_req1_valid;
    win_word = win ? i_req1_word : i_req0_word;
    win_len  = win ? i_req1_len  : i_req0_len;
  end

  // Next-state logic for the grant/send/wait sequencer and the watchdog.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    grant_d = grant_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = err_q;
    if (i_err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          grant_d = win;
          ack0_d  = ~win;
          ack1_d  = win;
          tmo_d   = '0;
          state_d = ST_SEND;
          // Left-align the bytes to send so the MSB byte is always on top.
          case (win_len)
            2'd1:    shift_d = win_word << (3 * DATA_BITS);
            2'd2:    shift_d = win_word << (2 * DATA_BITS);
            2'd3:    shift_d = win_word << DATA_BITS;
            default: shift_d = win_word;
          endcase
          cnt_d = (win_len == 2'd0) ? 3'd4 : {1'b0, win_len};
        end
      end
      ST_SEND: begin
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (!i_uart_tx_done) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (i_uart_tx_done) begin
          cnt_d = cnt_q - 3'd1;
          tmo_d = '0;
          if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end else begin
            shift_d = shift_q << DATA_BITS;
            state_d = ST_SEND;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; tx_ready and busy follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      grant_q    <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      grant_q    <= grant_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      tx_ready_q <= (state_d == ST_SEND);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign o_uart_tx_data  = shift_q[NBITS-1:NBITS-DATA_BITS];
  assign o_uart_tx_ready = tx_ready_q;
  assign o_req0_ack      = ack0_q;
  assign o_req1_ack      = ack1_q;
  assign o_busy          = busy_q;
  assign o_grant         = grant_q;
  assign o_error         = err_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_mips_uart_tx_arbiter.sv
// Directed bench for mips_uart_tx_arbiter: a UART responder model checks
// every transmitted byte against an expected queue; the stimulus steps
// through single words, partial lengths, round-robin, watchdog, reset and
// withdraw cases.
module tb_mips_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic        v0, v1;
  logic [31:0] w0, w1;
  logic [1:0]  l0, l1;
  logic        ack0, ack1;
  logic        uart_done;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err_clr;
  logic        busy;
  logic        grant;
  logic        error;
  logic [1:0]  dbg_state;

  logic        uart_stall;
  logic [7:0]  exp_q[$];
  int          n_assert;
  int          n_fail;

  mips_uart_tx_arbiter #(
    .NBITS(32), .DATA_BITS(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req0_valid(v0), .i_req0_word(w0), .i_req0_len(l0), .o_req0_ack(ack0),
    .i_req1_valid(v1), .i_req1_word(w1), .i_req1_len(l1), .o_req1_ack(ack1),
    .i_uart_tx_done(uart_done), .o_uart_tx_data(tx_data),
    .o_uart_tx_ready(tx_ready), .i_err_clr(err_clr), .o_busy(busy),
    .o_grant(grant), .o_error(error), .o_dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART responder: takes a byte, drops done 2 cycles later, raises it 10 later.
  initial begin : uart_model
    uart_done = 1'b1;
    forever begin
      @(negedge clk);
      if (!uart_stall && uart_done && tx_ready) begin
        check("uart_byte", {24'd0, tx_data},
              (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'h1FF);
        repeat (2) @(negedge clk);
        uart_done = 1'b0;
        repeat (10) @(negedge clk);
        uart_done = 1'b1;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle_in_time"}, (i < 500), 1);
    check({tag, "_all_bytes"}, exp_q.size(), 0);
  endtask

  task automatic send_word(input logic sel, input logic [31:0] w,
                           input logic [1:0] len, input string tag);
    if (!sel) begin v0 = 1'b1; w0 = w; l0 = len; end
    else      begin v1 = 1'b1; w1 = w; l1 = len; end
    @(negedge clk);
    check({tag, "_ack"}, sel ? ack1 : ack0, 1);
    check({tag, "_grant"}, grant, sel);
    check({tag, "_busy"}, busy, 1);
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    check({tag, "_ack_once"}, ack0 | ack1, 0);
    wait_idle(tag);
  endtask

  // Stalled UART: count tx_ready cycles until the watchdog fires.
  task automatic run_timeout(input string tag, input logic clr_at_abort);
    int n;
    n = 0;
    uart_stall = 1'b1;
    v0 = 1'b1; w0 = 32'h55; l0 = 2'd1;
    @(negedge clk);
    check({tag, "_ack"}, ack0, 1);
    v0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!tx_ready) break;
      n++;
      if (n == 15 && clr_at_abort) err_clr = 1'b1;
      @(negedge clk);
    end
    err_clr = 1'b0;
    check({tag, "_ready_cycles"}, n, 15);
    check({tag, "_error"}, error, 1);
    check({tag, "_ready_low"}, tx_ready, 0);
    check({tag, "_busy_low"}, busy, 0);
    uart_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stimulus
    int k, n0, n1, i;
    n_assert = 0; n_fail = 0;
    uart_stall = 1'b0;
    reset = 1'b1; err_clr = 1'b0;
    v0 = 1'b0; v1 = 1'b0; w0 = '0; w1 = '0; l0 = '0; l1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 0);
    check("rst_data", tx_data, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 1);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single 4-byte word
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_word(1'b0, 32'h11223344, 2'd0, "w4");
    check("w4_grant_after", grant, 0);

    // Partial lengths
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    send_word(1'b1, 32'hAABBCCDD, 2'd2, "len2");
    exp_q.push_back(8'hDD);
    send_word(1'b1, 32'hAABBCCDD, 2'd1, "len1");
    exp_q.push_back(8'hBB); exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    send_word(1'b1, 32'hAABBCCDD, 2'd3, "len3");

    // Round-robin with both requesters valid continuously
    do_reset();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hB2);
    v0 = 1'b1; w0 = 32'hA1; l0 = 2'd1;
    v1 = 1'b1; w1 = 32'hB1; l1 = 2'd1;
    k = 0; n0 = 0; n1 = 0;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check("rr_ack_sel", ack1, k % 2);
        check("rr_grant", grant, k % 2);
        if (ack0) begin n0++; if (n0 == 1) w0 = 32'hA2; else v0 = 1'b0; end
        if (ack1) begin n1++; if (n1 == 1) w1 = 32'hB2; else v1 = 1'b0; end
        k++;
      end
      if (k == 4 && !busy) break;
    end
    check("rr_words", k, 4);
    check("rr_ack0_pulses", n0, 2);
    check("rr_ack1_pulses", n1, 2);
    check("rr_all_bytes", exp_q.size(), 0);

    // Watchdog, then clear colliding with a second timeout, then clear
    run_timeout("tmo1", 1'b0);
    run_timeout("tmo_clr", 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", error, 0);
    exp_q.push_back(8'h5A);
    send_word(1'b0, 32'h0000005A, 2'd1, "after_tmo");
    check("after_tmo_error", error, 0);

    // Reset in the middle of a word
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    v0 = 1'b1; w0 = 32'h01020304; l0 = 2'd0;
    @(negedge clk);
    v0 = 1'b0;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("mid_two_bytes", (i < 400), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_ready", tx_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_grant", grant, 1);
    repeat (30) @(negedge clk);
    check("mid_still_idle", busy, 0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    send_word(1'b0, 32'h01020304, 2'd0, "restart");

    // Withdraw: req0 raised while busy and dropped before it can be granted
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    v1 = 1'b1; w1 = 32'h71; l1 = 2'd1;
    @(negedge clk);
    check("wd_ack1_first", ack1, 1);
    w1 = 32'h72;
    v0 = 1'b1; w0 = 32'h99; l0 = 2'd1;
    repeat (3) @(negedge clk);
    v0 = 1'b0;
    n0 = 0; k = 0;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ack0) n0++;
      if (ack1) begin k++; v1 = 1'b0; end
      if (k == 1 && !busy) break;
    end
    check("wd_ack1_second", k, 1);
    check("wd_no_ack0", n0, 0);
    check("wd_grant", grant, 1);
    check("wd_all_bytes", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_uart_tx_arbiter.md
Name: mips_uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two word-oriented requesters: requester 0 is the debug dump path and requester 1 is the console/echo path.
- Accepts one 32-bit word per grant and serializes 1-4 bytes, MSB first, through the UART tx_ready/tx_done handshake.
- Grants are round-robin.
- A watchdog aborts a transfer if the UART stalls and sets a sticky error flag.

Parameters:
- NBITS, 32, width of a request word.
- DATA_BITS, 8, width of one UART byte.
- TIMEOUT, 1024, maximum cycles spent in one SEND+WAIT byte phase before abort (>=4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has a word pending; held until o_req0_ack
- i_req0_word  in  NBITS  requester 0 word
- i_req0_len  in  2  bytes to send: 1-3 = that count, 0 = 4
- o_req0_ack  out  1  one-cycle pulse: requester 0 word accepted
- i_req1_valid, i_req1_word, i_req1_len, o_req1_ack  same as requester 0, for requester 1
- i_uart_tx_done  in  1  UART idle/done (high = idle; drops low once a byte is taken)
- o_uart_tx_data  out  DATA_BITS  byte to transmit
- o_uart_tx_ready  out  1  start request to UART
- i_err_clr  in  1  clears o_error
- o_busy  out  1  high whenever state != IDLE
- o_grant  out  1  requester currently/last granted
- o_error  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, o_uart_tx_data 0, o_uart_tx_ready 0, both acks 0, o_busy 0, o_grant 1 (so requester 0 wins first), o_error 0, shift register 0, byte counter 0, timeout counter 0. All outputs are registered.
- Reset mid-transfer: return to IDLE next cycle, drop remaining bytes, no ack.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester != o_grant.
  - On grant, next cycle: o_grant <= winner; ack pulse for winner (exactly 1 cycle); shift <= word << ((4-len)*DATA_BITS), with len 0 treated as 4; byte counter <= len (0 -> 4); timeout <= 0; state -> SEND.
  - Net effect: the least-significant len bytes are sent, MSB first.
  - A requester dropping valid before ack withdraws its request with no effect.
- SEND:
  - o_uart_tx_data = shift[NBITS-1:NBITS-DATA_BITS] and o_uart_tx_ready = 1.
  - When i_uart_tx_done sampled 0: tx_ready <= 0, timeout <= 0, state -> WAIT.
- WAIT:
  - When i_uart_tx_done sampled 1: counter decrements.
  - If the decremented count is 0: state -> IDLE, and the next grant can start the following cycle.
  - Otherwise: shift <<= DATA_BITS and state -> SEND.
- Timeout:
  - In SEND/WAIT the counter increments each cycle; it is cleared on every SEND/WAIT entry.
  - On reaching TIMEOUT-1: o_error <= 1, tx_ready <= 0, state -> IDLE, remaining bytes discarded; the ack has already been given.
- Error flag: i_err_clr clears o_error; a timeout in the same cycle wins (o_error stays 1). o_error does not block new grants.
- Requests raised while busy wait in IDLE; there is no preemption mid-word.
- Minimum cost per word: 1 IDLE cycle + per byte ≥1 SEND + ≥1 WAIT cycle.
- The timeout counter width is $clog2(TIMEOUT) and saturation never occurs.

Test Plan:
- Single 4-byte word: req0 valid, word 0x11223344, len 0; UART model drops done 2 cycles after tx_ready and raises it 10 cycles later -> o_req0_ack one pulse the cycle after valid; bytes 0x11,0x22,0x33,0x44 in order; o_busy falls after the 4th done; o_grant=0.
- Partial length: req1 word 0xAABBCCDD, len 2 -> exactly 2 bytes, 0xCC then 0xDD; len 1 -> 0xDD only; len 3 -> 0xBB,0xCC,0xDD.
- Round-robin: both valid continuously after reset -> grants alternate 0,1,0,1 over 4 words; each ack pulses once per word; no byte interleaving between words.
- Timeout: TIMEOUT=16, i_uart_tx_done held 1 after tx_ready -> o_error=1 at cycle 15 of SEND, tx_ready drops, back to IDLE; i_err_clr pulse -> o_error=0; the next word transmits normally.
- Reset mid-word: assert reset after the 2nd byte of 0x01020304 -> next cycle tx_ready=0, busy=0, grant=1, and no further bytes. A subsequent request restarts from byte 0x01.
- Withdraw/simultaneous: req0 valid then dropped before the ack cycle while req1 valid -> only req1 granted. i_err_clr and timeout in the same cycle -> o_error stays 1.
